cmd_param_bank: RTL and testbench

//  Multi-channel command-frame decoder and parameter register bank; next generation of the single-set

---
 rtl/cmd_param_bank.sv | 204 ++++++++++++++++++++
 tb/tb_cmd_param_bank.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_param_bank.sv
// Command-frame decoder and parameter bank: checks a frame, then updates flags,
// per-channel VC sweep sets (optionally staged behind COMMIT) and FAIMS timing.
module cmd_param_bank #(
    parameter int FRAME_BITS = 64,
    parameter int NCHAN      = 4,
    parameter int VC_W       = 12,
    parameter int STAGED     = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_frame_valid,
    output logic                    o_frame_ready,
    input  logic [FRAME_BITS-1:0]   i_mem,
    output logic [8:0]              o_flags,
    output logic [NCHAN*VC_W-1:0]   o_vc_step,
    output logic [NCHAN*VC_W-1:0]   o_vc_repeats,
    output logic [NCHAN*VC_W-1:0]   o_vc_start,
    output logic [NCHAN*VC_W-1:0]   o_vc_steps,
    output logic [NCHAN-1:0]        o_vc_reset,
    output logic [7:0]              o_faims_coil,
    output logic [9:0]              o_faims_period,
    output logic [9:0]              o_faims_pulse,
    output logic                    o_faims_reset,
    output logic [7:0]              o_err_cnt,
    output logic [NCHAN-1:0]        o_pending
);

    localparam int         NBYTES    = FRAME_BITS / 8;
    localparam logic [8:0] FLAGS_DEF = 9'h041;
    localparam logic [3:0] OP_FLAGS  = 4'd1;
    localparam logic [3:0] OP_VC     = 4'd2;
    localparam logic [3:0] OP_FAIMS  = 4'd3;
    localparam logic [3:0] OP_COMMIT = 4'd4;
    localparam logic [3:0] CHAN_ALL  = 4'hF;

    typedef logic [VC_W-1:0] vc_t;
    typedef struct packed {
        vc_t steps;
        vc_t start;
        vc_t repeats;
        vc_t step;
    } vc_set_t;

    localparam vc_set_t VC_DEF = '{steps: vc_t'(1024), start: vc_t'(0),
                                   repeats: vc_t'(1024), step: vc_t'(4)};

    // Fields arrive serially, so the lowest frame bit of a field is its MSB.
    function automatic logic [31:0] msb_first(input logic [FRAME_BITS-1:0] f,
                                              input int pos, input int w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < w; b++) r[w-1-b] = f[pos+b];
        return r;
    endfunction

    logic [1:0]                  vld_q, vld_d;
    logic [FRAME_BITS-1:0]       frame_q, frame_d;
    logic [8:0]                  flags_q, flags_d;
    vc_set_t [NCHAN-1:0]         live_q, live_d;
    vc_set_t [NCHAN-1:0]         shadow_q, shadow_d;
    logic [NCHAN-1:0]            pending_q, pending_d;
    logic [NCHAN-1:0]            vc_reset_q, vc_reset_d;
    logic [7:0]                  coil_q, coil_d;
    logic [9:0]                  period_q, period_d;
    logic [9:0]                  pulse_q, pulse_d;
    logic                        faims_reset_q, faims_reset_d;
    logic [7:0]                  err_q, err_d;

    logic       accept;
    logic [3:0] opcode;
    logic [3:0] chan;
    logic [7:0] csum;
    logic       chan_ok;
    logic       frame_ok;
    vc_set_t    vc_new;

    // Busy for the two cycles a frame spends in check and update.
    assign o_frame_ready = ~|vld_q;

    always_comb begin
        accept  = i_frame_valid && o_frame_ready;
        vld_d   = {vld_q[0], accept};
        frame_d = accept ? i_mem : frame_q;

        opcode = frame_q[3:0];
        chan   = frame_q[7:4];
        csum   = '0;
        for (int i = 0; i < NBYTES; i++) csum = csum ^ frame_q[i*8 +: 8];
        chan_ok = 32'(chan) < NCHAN;

        frame_ok = 1'b0;
        if (csum == 8'h00) begin
            case (opcode)
                OP_FLAGS, OP_FAIMS: frame_ok = 1'b1;
                OP_VC:              frame_ok = chan_ok;
                OP_COMMIT:          frame_ok = chan_ok || (chan == CHAN_ALL);
                default:            frame_ok = 1'b0;
            endcase
        end

        vc_new.step    = vc_t'(msb_first(frame_q, 8,          VC_W));
        vc_new.repeats = vc_t'(msb_first(frame_q, 8 + VC_W,   VC_W));
        vc_new.start   = vc_t'(msb_first(frame_q, 8 + 2*VC_W, VC_W));
        vc_new.steps   = vc_t'(msb_first(frame_q, 8 + 3*VC_W, VC_W));

        flags_d       = flags_q;
        live_d        = live_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        coil_d        = coil_q;
        period_d      = period_q;
        pulse_d       = pulse_q;
        err_d         = err_q;
        vc_reset_d    = '0;
        faims_reset_d = 1'b0;

        if (vld_q[0]) begin
            if (!frame_ok) begin
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end else begin
                case (opcode)
                    OP_FLAGS: flags_d = frame_q[16:8];
                    OP_VC: begin
                        for (int c = 0; c < NCHAN; c++) begin
                            if (chan == 4'(c)) begin
                                if (STAGED != 0) begin
                                    shadow_d[c]  = vc_new;
                                    pending_d[c] = 1'b1;
                                end else begin
                                    live_d[c]     = vc_new;
                                    vc_reset_d[c] = 1'b1;
                                end
                            end
                        end
                    end
                    OP_FAIMS: begin
                        coil_d        = 8'(msb_first(frame_q, 8, 8));
                        period_d      = 10'(msb_first(frame_q, 16, 10));
                        pulse_d       = 10'(msb_first(frame_q, 26, 10));
                        faims_reset_d = 1'b1;
                    end
                    OP_COMMIT: begin
                        // Only channels holding uncommitted data restart.
                        for (int c = 0; c < NCHAN; c++) begin
                            if (((chan == CHAN_ALL) || (chan == 4'(c))) && pending_q[c]) begin
                                live_d[c]     = shadow_q[c];
                                vc_reset_d[c] = 1'b1;
                                pending_d[c]  = 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vld_q         <= '0;
            frame_q       <= '0;
            flags_q       <= FLAGS_DEF;
            live_q        <= {NCHAN{VC_DEF}};
            shadow_q      <= {NCHAN{VC_DEF}};
            pending_q     <= '0;
            vc_reset_q    <= '0;
            coil_q        <= '0;
            period_q      <= '0;
            pulse_q       <= '0;
            faims_reset_q <= 1'b0;
            err_q         <= '0;
        end else begin
            vld_q         <= vld_d;
            frame_q       <= frame_d;
            flags_q       <= flags_d;
            live_q        <= live_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            vc_reset_q    <= vc_reset_d;
            coil_q        <= coil_d;
            period_q      <= period_d;
            pulse_q       <= pulse_d;
            faims_reset_q <= faims_reset_d;
            err_q         <= err_d;
        end
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan_out
        assign o_vc_step[c*VC_W +: VC_W]    = live_q[c].step;
        assign o_vc_repeats[c*VC_W +: VC_W] = live_q[c].repeats;
        assign o_vc_start[c*VC_W +: VC_W]   = live_q[c].start;
        assign o_vc_steps[c*VC_W +: VC_W]   = live_q[c].steps;
    end

    assign o_flags        = flags_q;
    assign o_vc_reset     = vc_reset_q;
    assign o_faims_coil   = coil_q;
    assign o_faims_period = period_q;
    assign o_faims_pulse  = pulse_q;
    assign o_faims_reset  = faims_reset_q;
    assign o_err_cnt      = err_q;
    assign o_pending      = pending_q;

endmodule

// File: tb/tb_cmd_param_bank.sv
// Bench for cmd_param_bank: an immediate (STAGED=0) and a staged (STAGED=1) instance
// share one frame stream and are compared against a frame-level reference model.
module tb_cmd_param_bank;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid = 1'b0;
    logic [63:0] mem = '0;

    logic [1:0]        ready;
    logic [1:0][8:0]   flags;
    logic [1:0][47:0]  vstep, vrep, vstart, vsteps;
    logic [1:0][3:0]   vrst, pend;
    logic [1:0][7:0]   coil, err;
    logic [1:0][9:0]   per, pul;
    logic [1:0]        frst;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cmd_param_bank #(.FRAME_BITS(64), .NCHAN(4), .VC_W(12), .STAGED(g)) u_dut (
            .i_clk(clk), .i_rstn(rstn), .i_frame_valid(valid), .o_frame_ready(ready[g]),
            .i_mem(mem), .o_flags(flags[g]), .o_vc_step(vstep[g]), .o_vc_repeats(vrep[g]),
            .o_vc_start(vstart[g]), .o_vc_steps(vsteps[g]), .o_vc_reset(vrst[g]),
            .o_faims_coil(coil[g]), .o_faims_period(per[g]), .o_faims_pulse(pul[g]),
            .o_faims_reset(frst[g]), .o_err_cnt(err[g]), .o_pending(pend[g]));
    end

    // ---------------- reference model (index 0: immediate, 1: staged) ----------------
    int       m_live[2][4][4];   // [inst][chan][step,repeats,start,steps]
    int       m_sh[2][4][4];
    bit [3:0] m_pend[2];
    bit [3:0] m_vcrst[2];
    int       m_flags, m_coil, m_per, m_pul, m_err;
    bit       m_frst;

    function automatic int fld(input logic [63:0] f, input int pos, input int w);
        int r = 0;
        for (int b = 0; b < w; b++) r = (r << 1) | int'(f[pos+b]);
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 4; c++) begin
                m_live[s][c] = '{4, 1024, 0, 1024};
                m_sh[s][c]   = '{4, 1024, 0, 1024};
            end
            m_pend[s]  = '0;
            m_vcrst[s] = '0;
        end
        m_flags = 'h041; m_coil = 0; m_per = 0; m_pul = 0; m_err = 0; m_frst = 0;
    endtask

    task automatic model_apply(input logic [63:0] f);
        int op, ch;
        logic [7:0] x;
        bit ok;
        op = int'(f[3:0]);
        ch = int'(f[7:4]);
        x = '0;
        for (int i = 0; i < 8; i++) x = x ^ f[i*8 +: 8];
        ok = (x == 8'h00) && (op >= 1) && (op <= 4);
        if (op == 2 && ch >= 4) ok = 0;
        if (op == 4 && ch >= 4 && ch != 15) ok = 0;
        if (!ok) begin
            if (m_err < 255) m_err++;
            return;
        end
        case (op)
            1: m_flags = int'(f[16:8]);
            2: begin
                if (1) begin
                    for (int i = 0; i < 4; i++) begin
                        m_live[0][ch][i] = fld(f, 8 + 12*i, 12);
                        m_sh[1][ch][i]   = fld(f, 8 + 12*i, 12);
                    end
                    m_vcrst[0][ch] = 1'b1;
                    m_pend[1][ch]  = 1'b1;
                end
            end
            3: begin
                m_coil = fld(f, 8, 8); m_per = fld(f, 16, 10); m_pul = fld(f, 26, 10);
                m_frst = 1;
            end
            default: begin
                for (int s = 0; s < 2; s++)
                    for (int c = 0; c < 4; c++)
                        if ((ch == 15 || ch == c) && m_pend[s][c]) begin
                            m_live[s][c] = m_sh[s][c];
                            m_vcrst[s][c] = 1'b1;
                            m_pend[s][c] = 1'b0;
                        end
            end
        endcase
    endtask

    // ---------------- frame builders ----------------
    function automatic logic [63:0] put(input logic [63:0] f, input int pos, input int w, input int val);
        logic [63:0] r = f;
        for (int b = 0; b < w; b++) r[pos+b] = ((val >> (w-1-b)) & 1) != 0;
        return r;
    endfunction

    function automatic logic [63:0] seal(input logic [63:0] f);
        logic [63:0] r = f;
        logic [7:0] x = '0;
        for (int i = 0; i < 7; i++) x = x ^ r[i*8 +: 8];
        r[63:56] = x;
        return r;
    endfunction

    function automatic logic [63:0] mk_cmd(input int op, input int ch);
        logic [63:0] f = '0;
        f[3:0] = 4'(op);
        f[7:4] = 4'(ch);
        return seal(f);
    endfunction

    function automatic logic [63:0] mk_vc(input int ch, input int a, input int b, input int c, input int d);
        logic [63:0] f = mk_cmd(2, ch);
        f = put(f, 8, 12, a); f = put(f, 20, 12, b); f = put(f, 32, 12, c); f = put(f, 44, 12, d);
        return seal(f);
    endfunction

    function automatic logic [63:0] mk_faims(input int cl, input int pe, input int pu);
        logic [63:0] f = mk_cmd(3, 0);
        f = put(f, 8, 8, cl); f = put(f, 16, 10, pe); f = put(f, 26, 10, pu);
        return seal(f);
    endfunction

    function automatic logic [63:0] mk_flags(input logic [8:0] fl);
        logic [63:0] f = mk_cmd(1, 0);
        f[16:8] = fl;
        return seal(f);
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input logic exp_ready);
        logic [47:0] es, er, est, ess;
        for (int s = 0; s < 2; s++) begin
            es = '0; er = '0; est = '0; ess = '0;
            for (int c = 0; c < 4; c++) begin
                es[c*12 +: 12]  = 12'(m_live[s][c][0]);
                er[c*12 +: 12]  = 12'(m_live[s][c][1]);
                est[c*12 +: 12] = 12'(m_live[s][c][2]);
                ess[c*12 +: 12] = 12'(m_live[s][c][3]);
            end
            chk($sformatf("ready[%0d]", s),    64'(ready[s]),  64'(exp_ready));
            chk($sformatf("flags[%0d]", s),    64'(flags[s]),  64'(m_flags));
            chk($sformatf("vc_step[%0d]", s),  64'(vstep[s]),  64'(es));
            chk($sformatf("vc_rep[%0d]", s),   64'(vrep[s]),   64'(er));
            chk($sformatf("vc_start[%0d]", s), 64'(vstart[s]), 64'(est));
            chk($sformatf("vc_steps[%0d]", s), 64'(vsteps[s]), 64'(ess));
            chk($sformatf("vc_reset[%0d]", s), 64'(vrst[s]),   64'(m_vcrst[s]));
            chk($sformatf("pending[%0d]", s),  64'(pend[s]),   64'(m_pend[s]));
            chk($sformatf("coil[%0d]", s),     64'(coil[s]),   64'(m_coil));
            chk($sformatf("period[%0d]", s),   64'(per[s]),    64'(m_per));
            chk($sformatf("pulse[%0d]", s),    64'(pul[s]),    64'(m_pul));
            chk($sformatf("faims_rst[%0d]", s), 64'(frst[s]),  64'(m_frst));
            chk($sformatf("err_cnt[%0d]", s),  64'(err[s]),    64'(m_err));
        end
    endtask

    task automatic clear_pulses();
        m_vcrst[0] = '0; m_vcrst[1] = '0; m_frst = 0;
    endtask

    // One frame: offered for one cycle, busy check, result at N+2, pulses gone at N+3.
    task automatic send_frame(input logic [63:0] f, output logic [1:0][3:0] seen);
        @(negedge clk); valid = 1'b1; mem = f;
        @(negedge clk); valid = 1'b0; check_all(1'b0);
        model_apply(f);
        @(negedge clk); check_all(1'b0); seen = vrst;
        clear_pulses();
        @(negedge clk); check_all(1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk); rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_reset();
        check_all(1'b1);
    endtask

    typedef struct {
        logic [63:0] frame;
        logic [3:0]  rst0;
        logic [3:0]  rst1;
        logic        rej;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [1:0][3:0] seen;
        logic [7:0] e0;
        logic [63:0] f;
        int op, ch;

        // T1: reset held three cycles
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        model_reset();
        check_all(1'b1);
        chk("t1_flags", 64'(flags[0]), 64'h041);
        chk("t1_step_ch3", 64'(vstep[1][47:36]), 64'd4);
        chk("t1_rep_ch0", 64'(vrep[0][11:0]), 64'd1024);

        tbl[0]  = '{mk_vc(2, 7, 100, 5, 2000),     4'b0100, 4'b0000, 1'b0};
        tbl[1]  = '{mk_vc(1, 9, 1, 2, 3),          4'b0010, 4'b0000, 1'b0};
        tbl[2]  = '{mk_vc(3, 3, 4095, 4095, 1),    4'b1000, 4'b0000, 1'b0};
        tbl[3]  = '{mk_cmd(4, 15),                 4'b0000, 4'b1110, 1'b0};
        tbl[4]  = '{mk_cmd(4, 0),                  4'b0000, 4'b0000, 1'b0};
        tbl[5]  = '{mk_vc(0, 1, 1, 1, 1) ^ 64'h1000_0000_0000_0000, 4'b0000, 4'b0000, 1'b1};
        tbl[6]  = '{mk_cmd(9, 0),                  4'b0000, 4'b0000, 1'b1};
        tbl[7]  = '{mk_vc(5, 1, 2, 3, 4),          4'b0000, 4'b0000, 1'b1};
        tbl[8]  = '{mk_cmd(4, 4),                  4'b0000, 4'b0000, 1'b1};
        tbl[9]  = '{mk_faims('hA5, 300, 17),       4'b0000, 4'b0000, 1'b0};
        tbl[10] = '{mk_flags(9'h1AB),              4'b0000, 4'b0000, 1'b0};
        tbl[11] = '{mk_cmd(0, 0),                  4'b0000, 4'b0000, 1'b1};
        tbl[12] = '{mk_vc(0, 10, 20, 30, 40),      4'b0001, 4'b0000, 1'b0};
        tbl[13] = '{mk_cmd(4, 0),                  4'b0000, 4'b0001, 1'b0};
        tbl[14] = '{mk_cmd(4, 15),                 4'b0000, 4'b0000, 1'b0};
        tbl[15] = '{mk_vc(15, 1, 2, 3, 4),         4'b0000, 4'b0000, 1'b1};

        for (int i = 0; i < 16; i++) begin
            e0 = err[0];
            send_frame(tbl[i].frame, seen);
            chk($sformatf("tbl%0d_rst0", i), 64'(seen[0]), 64'(tbl[i].rst0));
            chk($sformatf("tbl%0d_rst1", i), 64'(seen[1]), 64'(tbl[i].rst1));
            chk($sformatf("tbl%0d_err", i), 64'(err[0]), 64'(e0 + 8'(tbl[i].rej)));
        end
        chk("t2_ch2_steps", 64'(vsteps[0][35:24]), 64'd2000);
        chk("flags_1ab", 64'(flags[1]), 64'h1AB);

        // T3: staged writes then COMMIT all
        do_reset();
        send_frame(mk_vc(1, 9, 50, 6, 7), seen);
        send_frame(mk_vc(3, 3, 60, 8, 9), seen);
        chk("t3_pending", 64'(pend[1]), 64'b1010);
        chk("t3_live_ch1", 64'(vstep[1][23:12]), 64'd4);
        send_frame(mk_cmd(4, 15), seen);
        chk("t3_commit_rst", 64'(seen[1]), 64'b1010);
        chk("t3_pending_clr", 64'(pend[1]), 64'b0000);
        chk("t3_live_ch3", 64'(vstep[1][47:36]), 64'd3);

        // T5: valid held three cycles; frames 2 and 3 would be rejects if seen
        @(negedge clk); valid = 1'b1; mem = mk_faims(1, 1, 1);
        @(negedge clk); mem = mk_cmd(9, 0); check_all(1'b0);
        model_apply(mk_faims(1, 1, 1));
        @(negedge clk); mem = mk_faims(3, 3, 3) ^ 64'h1; check_all(1'b0);
        clear_pulses();
        @(negedge clk); valid = 1'b0; check_all(1'b1);
        repeat (3) @(negedge clk);
        check_all(1'b1);
        chk("t5_coil", 64'(coil[0]), 64'd1);

        // T6: reset lands while a FAIMS frame is in flight
        send_frame(mk_vc(0, 11, 12, 13, 14), seen);
        @(negedge clk); valid = 1'b1; mem = mk_faims('hA5, 5, 6);
        @(negedge clk); valid = 1'b0; rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        model_reset();
        check_all(1'b1);
        chk("t6_coil", 64'(coil[0]), 64'd0);
        chk("t6_pending", 64'(pend[1]), 64'd0);
        @(negedge clk); check_all(1'b1);

        // Random frames against the model
        for (int n = 0; n < 250; n++) begin
            op = int'($urandom_range(0, 9));
            ch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            if (op <= 2)      f = mk_vc(ch, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                                        int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
            else if (op <= 4) f = mk_faims(int'($urandom_range(0, 255)), int'($urandom_range(0, 1023)),
                                           int'($urandom_range(0, 1023)));
            else if (op == 5) f = mk_flags(9'($urandom_range(0, 511)));
            else if (op <= 7) f = mk_cmd(4, ($urandom_range(0, 1) == 0) ? 15 : ch);
            else              f = seal({$urandom(), $urandom()});
            if ($urandom_range(0, 9) == 0) f[$urandom_range(0, 63)] ^= 1'b1;
            send_frame(f, seen);
        end

        // T4: three rejects, then saturation
        do_reset();
        send_frame(mk_vc(0, 1, 1, 1, 1) ^ 64'h0100_0000_0000_0000, seen);
        send_frame(mk_cmd(9, 0), seen);
        send_frame(mk_vc(5, 1, 2, 3, 4), seen);
        chk("t4_err3", 64'(err[1]), 64'd3);
        for (int n = 0; n < 300; n++) send_frame(mk_cmd(4, 7), seen);
        chk("t4_err_sat0", 64'(err[0]), 64'd255);
        chk("t4_err_sat1", 64'(err[1]), 64'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
